// File: rtl/div4_arbiter_if.sv
// Bundle of requester-side and consumer-side handshake signals for div4_arbiter.
// rr_ptr is a read-only debug view of the arbiter's round-robin pointer.
interface div4_arbiter_if #(
    parameter int N    = 4,
    parameter int REQS = 4
);
    localparam int IDW = $clog2(REQS);

    logic [REQS-1:0]   req_valid;
    logic [REQS*N-1:0] req_data;
    logic [REQS-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic              out_d;
    logic [N-1:0]      out_x;
    logic [IDW-1:0]    out_id;
    logic [IDW-1:0]    rr_ptr;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_d, out_x, out_id, rr_ptr
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_d, out_x, out_id, rr_ptr
    );
endinterface

// File: rtl/div4_arbiter.sv
// Round-robin arbiter feeding one shared x%4==0 check into a single registered output stage.
// Optional saturating transfer counters are enabled with `define DIV4_ARB_STATS_EN.
module div4_arbiter #(
    parameter int N    = 4,
    parameter int REQS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    div4_arbiter_if.slave bus
`ifdef DIV4_ARB_STATS_EN
    ,
    output logic [15:0]   stat_total,
    output logic [15:0]   stat_div
`endif
);
    localparam int IDW = $clog2(REQS);

    // Handshake: a transfer happens on any cycle where valid and ready are both high;
    // valid never waits on ready, and ready reaches requesters only through can_load.
    logic [IDW-1:0]  rr_ptr;
    logic            can_load;
    logic            out_fire;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic [N-1:0]    grant_x;
    logic [REQS-1:0] ready;
    int              idx;

    assign out_fire = bus.out_valid && bus.out_ready;
    assign can_load = !bus.out_valid || bus.out_ready;

    // Search rr_ptr+1 .. rr_ptr+REQS, wrapping explicitly so indices >= REQS never occur.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = 0;
        if (can_load) begin
            for (int k = 1; k <= REQS; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= REQS) idx = idx - REQS;
                if (!grant_valid && bus.req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = IDW'(idx);
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_valid) ready[grant_id] = 1'b1;
    end

    assign bus.req_ready = ready;
    assign grant_x       = bus.req_data[int'(grant_id)*N +: N];
    assign bus.rr_ptr    = rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_d     <= 1'b0;
            bus.out_x     <= '0;
            bus.out_id    <= '0;
            rr_ptr        <= IDW'(REQS - 1);
        end else if (grant_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_d     <= ~|grant_x[1:0];
            bus.out_x     <= grant_x;
            bus.out_id    <= grant_id;
            rr_ptr        <= grant_id;
        end else if (out_fire) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef DIV4_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total <= '0;
            stat_div   <= '0;
        end else if (out_fire) begin
            if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
            if (bus.out_d && stat_div != 16'hFFFF) stat_div <= stat_div + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_div4_arbiter.sv
// Bench for div4_arbiter: vector table for grants plus a scoreboard for results.
module tb_div4_arbiter;
    localparam int N    = 4;
    localparam int REQS = 4;
    localparam int IDW  = $clog2(REQS);
    localparam int W    = IDW + N + 1;

    logic clk;
    logic rst_n;

    div4_arbiter_if #(.N(N), .REQS(REQS)) bus ();

`ifdef DIV4_ARB_STATS_EN
    logic [15:0] stat_total;
    logic [15:0] stat_div;
`endif

    div4_arbiter #(.N(N), .REQS(REQS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef DIV4_ARB_STATS_EN
        ,
        .stat_total (stat_total),
        .stat_div   (stat_div)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [REQS-1:0]   valid;
        logic [REQS*N-1:0] data;
        logic              ordy;
        logic [REQS-1:0]   exp_ready;
    } vec_t;

    vec_t tbl[14];

    logic [W-1:0] exp_q[$];
    int           mptr;
    logic         mvalid;
    int           n_tests;
    int           n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [REQS-1:0] model_grant(input logic [REQS-1:0] v, input int ptr,
                                                    input logic can);
        logic [REQS-1:0] g;
        g = '0;
        if (can) begin
            for (int k = 1; k <= REQS; k++) begin
                if (g == '0 && v[(ptr + k) % REQS]) g[(ptr + k) % REQS] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        mptr   = REQS - 1;
        mvalid = 1'b0;
    endtask

    // One cycle: drive at negedge, check mid-cycle, advance the model at posedge.
    task automatic step(input logic [REQS-1:0] v, input logic [REQS*N-1:0] data, input logic ordy,
                        input logic use_tbl, input logic [REQS-1:0] tbl_ready);
        logic [REQS-1:0] eg;
        logic [W-1:0]    got;
        logic [N-1:0]    x;
        int              gi;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data  = data;
        bus.out_ready = ordy;
        #1;
        eg = model_grant(v, mptr, !mvalid || ordy);
        check("req_ready", 32'(bus.req_ready), 32'(eg));
        if (use_tbl) check("req_ready_tbl", 32'(bus.req_ready), 32'(tbl_ready));
        check("out_valid", 32'(bus.out_valid), 32'(mvalid));
        check("rr_ptr", 32'(bus.rr_ptr), 32'(mptr));
        if (mvalid) begin
            got = {bus.out_id, bus.out_x, bus.out_d};
            if (exp_q.size() == 0) check("result_queue_empty", 32'(got), 32'hDEAD);
            else                   check("result", 32'(got), 32'(exp_q[0]));
        end
        @(posedge clk);
        if (mvalid && ordy) begin
            void'(exp_q.pop_front());
            mvalid = 1'b0;
        end
        if (eg != '0) begin
            gi = 0;
            for (int i = 0; i < REQS; i++) if (eg[i]) gi = i;
            x = data[gi*N +: N];
            exp_q.push_back({IDW'(gi), x, (x % 4 == 0) ? 1'b1 : 1'b0});
            mptr   = gi;
            mvalid = 1'b1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;

        tbl[0]  = '{4'b1111, 16'hC854, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 16'hC854, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 16'hC854, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 16'hC854, 1'b1, 4'b1000};
        tbl[4]  = '{4'b0100, 16'h0600, 1'b1, 4'b0100};
        tbl[5]  = '{4'b1111, 16'hC854, 1'b0, 4'b0000};
        tbl[6]  = '{4'b1111, 16'hC854, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1111, 16'hC854, 1'b0, 4'b0000};
        tbl[8]  = '{4'b1111, 16'hC854, 1'b1, 4'b1000};
        tbl[9]  = '{4'b1010, 16'h00F0, 1'b1, 4'b0010};
        tbl[10] = '{4'b1010, 16'h00F0, 1'b1, 4'b1000};
        tbl[11] = '{4'b1010, 16'h00F0, 1'b1, 4'b0010};
        tbl[12] = '{4'b0001, 16'h000C, 1'b1, 4'b0001};
        tbl[13] = '{4'b0000, 16'h0000, 1'b1, 4'b0000};

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_out_x", 32'(bus.out_x), 32'h0);
        check("reset_out_id", 32'(bus.out_id), 32'h0);
        check("reset_out_d", 32'(bus.out_d), 32'h0);
        check("reset_rr_ptr", 32'(bus.rr_ptr), 32'(REQS - 1));
        rst_n = 1'b1;

        // Mid-stream reset: a held result must vanish immediately.
        for (int i = 0; i < 3; i++) step(4'b1111, 16'hC854, 1'b1, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(bus.out_valid), 32'h0);
        check("midreset_rr_ptr", 32'(bus.rr_ptr), 32'(REQS - 1));
        model_reset();
        @(posedge clk);
        #1;
        check("midreset_hold_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++)
            step(tbl[i].valid, tbl[i].data, tbl[i].ordy, 1'b1, tbl[i].exp_ready);
        step('0, '0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 1000; i++)
            step(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, '0);
        for (int i = 0; i < 3; i++) step('0, '0, 1'b1, 1'b0, '0);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

`ifdef DIV4_ARB_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("stat_total_reset", 32'(stat_total), 32'h0);
        check("stat_div_reset", 32'(stat_div), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            logic [N-1:0] vals[10];
            vals = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7};
            for (int i = 0; i < 10; i++) step(4'b0001, 16'(vals[i]), 1'b1, 1'b0, '0);
        end
        for (int i = 0; i < 2; i++) step('0, '0, 1'b1, 1'b0, '0);
        check("stat_total_10", 32'(stat_total), 32'd10);
        check("stat_div_4", 32'(stat_div), 32'd4);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;
        repeat (65540) @(posedge clk);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stat_total_sat", 32'(stat_total), 32'hFFFF);
        check("stat_div_sat", 32'(stat_div), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/div4_arbiter.md
Name: div4_arbiter

Overview:
Round-robin arbiter and sequencer that shares one divisible-by-4 check among REQS requesters. Each requester offers an N-bit operand over a valid/ready handshake. The block grants one requester per cycle, evaluates d = (x mod 4 == 0), and presents the result in a single registered output stage. The stage carries the operand and the requester ID and honours downstream backpressure. The block sits between multiple operand producers and one result consumer.

Parameters:
N, 4, operand width in bits; legal range 2..32
REQS, 4, number of requesters; legal range 2..16
IDW, $clog2(REQS), width of the requester ID field (derived; do not override)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
req_valid  input  REQS  bit i = requester i offers an operand
req_data  input  REQS*N  packed operands; requester i occupies bits [i*N +: N]
req_ready  output  REQS  one-hot or zero; bit i = requester i accepted this cycle
out_valid  output  1  result register holds a valid result
out_ready  input  1  consumer takes the result this cycle
out_d  output  1  1 when out_x is divisible by 4
out_x  output  N  operand that produced out_d
out_id  output  IDW  index of the requester that supplied out_x

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_d=0, out_x=0, out_id=0, rr_ptr=REQS-1. With that pointer, requester 0 has highest priority after reset.
- Handshakes:
  - Input transfer on a requester when req_valid[i] && req_ready[i].
  - Output transfer when out_valid && out_ready.
- can_load = !out_valid || out_ready.
- Grant is combinational:
  - When can_load is true, pick the first i with req_valid[i]=1.
  - Search order is rr_ptr+1, rr_ptr+2, ..., wrapping modulo REQS.
  - Drive req_ready[i]=1 for that i only.
  - When can_load is false or no request is valid, req_ready is all-zero.
- req_ready must not depend on out_valid/out_ready combinationally in any way other than through can_load. No loop through req_valid→req_ready on the same requester beyond the grant mux.
- On an input transfer from requester g, the next edge does the following:
  - out_x <= req_data[g]
  - out_d <= ~|req_data[g][1:0]
  - out_id <= g
  - out_valid <= 1
  - rr_ptr <= g
- Latency and throughput: input transfer at cycle t gives the result visible at cycle t+1. A transfer out and a transfer in on the same cycle are legal, so full throughput is 1 result per cycle.
- Output transfer with no new grant: out_valid <= 0. out_d, out_x and out_id hold their last values.
- Backpressure:
  - While out_valid && !out_ready, out_d/out_x/out_id/out_valid remain stable.
  - All req_ready are 0 during this time.
  - rr_ptr does not move.
- Fairness: a requester that holds req_valid continuously is granted within REQS accepted transfers.
- A requester may drop req_valid without a grant; no state is affected.
- Edge cases:
  - rr_ptr wrap: with rr_ptr=REQS-1, the search starts at 0.
  - REQS that is not a power of two: the search never visits indices >= REQS.
- Reset mid-operation: any held result is discarded, out_valid drops immediately, and the pointer returns to REQS-1.

Optional Feature:
DIV4_ARB_STATS_EN
- Defined: adds two outputs, stat_total (16 bits) and stat_div (16 bits).
  - stat_total increments on every output transfer.
  - stat_div increments on output transfers with out_d=1.
  - Both saturate at 16'hFFFF.
  - Both reset to 0 on rst_n low.
- Undefined: these ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset with out_ready=1: assert rst_n=0 mid-stream, then release; all req_valid=1 with data 0x4,0x5,0x8,0xC -> out_valid=0 during reset. First result after release is id=0, x=4, d=1; then id=1 d=0, id=2 d=1, id=3 d=1 on consecutive cycles.
- Single requester 2, x=0x6, out_ready=1 -> req_ready=4'b0100 in cycle t. At t+1: out_valid=1, out_x=6, out_d=0, out_id=2.
- Backpressure: out_ready=0 for 3 cycles with all requesters valid -> req_ready=0 throughout, output stable. Raise out_ready -> next grant follows rr_ptr order without skipping.
- Sparse requests: requesters 1 and 3 only valid with rr_ptr=3 -> grant 1, then 3, then 1. Confirms wrap and fairness.
- Boundary operands with N=4: x=0 -> d=1; x=0xF -> d=0; x=0xC -> d=1. Cross-check every result against (x % 4 == 0) over 1000 random cycles with random out_ready.
- With DIV4_ARB_STATS_EN: 10 transfers, 4 of them divisible -> stat_total=10, stat_div=4. Force 65540 transfers -> stat_total=16'hFFFF.
